// File: rtl/line_gen_pkg.sv
// Shared defaults, LFSR tap constant and next-state function for the obstacle line generator.
package line_gen_pkg;

  localparam int unsigned WIDTH_DEF = 640;
  localparam int unsigned GAP_W_DEF = 128;
  localparam int unsigned LFSR_W    = 8;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t LFSR_SEED_DEF = 8'hA5;
  // Taps 8,6,5,4 in polynomial terms map to register bits 7,5,4,3
  localparam lfsr_t LFSR_TAPS     = 8'b1011_1000;

  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/line_generate_lfsr8.sv
// 8-bit Fibonacci LFSR with advance enable and recovery from the all-zero lock state.
module lfsr8
  import line_gen_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  adv,
  input  lfsr_t seed,
  output lfsr_t state
);

  // A zero state would lock the register forever, so it reloads the seed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= seed;
    end else if (state == '0) begin
      state <= seed;
    end else if (adv) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/line_generate.sv
// Obstacle row generator: solid wall with one LFSR-placed gap, advanced by clk_lfsr rising edges.
// Define LINE_GEN_SYNC_EN to add a two-flop synchronizer on an asynchronous clk_lfsr.
module line_generate
  import line_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned GAP_W     = GAP_W_DEF,
  parameter lfsr_t       LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_lfsr,
  input  logic             en_i,
  output logic [WIDTH-1:0] line_o,
  output logic [7:0]       rand_num
);

  // Largest gap start is 2*255; the gap must never run past the row end
  if (2 * 255 + GAP_W > WIDTH) begin : g_width_check
    $error("line_generate: WIDTH too small for GAP_W");
  end
  if (LFSR_SEED == '0) begin : g_seed_check
    $error("line_generate: LFSR_SEED must be non-zero");
  end

  logic  strobe_sync;
  logic  strobe_prev;
  logic  rise_c;
  logic  adv_c;
  lfsr_t lfsr_state;

`ifdef LINE_GEN_SYNC_EN
  logic strobe_meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
    end else begin
      strobe_meta <= clk_lfsr;
      strobe_sync <= strobe_meta;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_sync <= 1'b0;
    end else begin
      strobe_sync <= clk_lfsr;
    end
  end
`endif

  // Edge detector keeps tracking the level even while disabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_prev <= 1'b0;
    end else begin
      strobe_prev <= strobe_sync;
    end
  end

  assign rise_c = strobe_sync & ~strobe_prev;
  assign adv_c  = rise_c & en_i;

  lfsr8 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv   (adv_c),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  assign rand_num = lfsr_state;

  logic [WIDTH-1:0] mask_c;
  int unsigned      gap_start_c;
  int unsigned      gap_end_c;

  // One range comparison per pixel; bit i is pixel x = i
  always_comb begin
    gap_start_c = {23'd0, lfsr_state, 1'b0};
    gap_end_c   = gap_start_c + GAP_W;
    mask_c      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      mask_c[i] = (i < gap_start_c) || (i >= gap_end_c);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_o <= '0;
    end else if (en_i) begin
      line_o <= mask_c;
    end else begin
      line_o <= '0;
    end
  end

endmodule

// File: tb/tb_line_generate.sv
// Randomized self-checking bench for line_generate against a behavioural row/LFSR model.
module tb_line_generate;

  localparam int unsigned W   = 640;
  localparam int unsigned GAP = 128;
`ifdef LINE_GEN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           clk_lfsr;
  logic           en_i;
  logic [W-1:0]   line_o;
  logic [7:0]     rand_num;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model;

  line_generate dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clk_lfsr (clk_lfsr),
    .en_i     (en_i),
    .line_o   (line_o),
    .rand_num (rand_num)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] r);
    int ones;
    ones = int'(r[7]) + int'(r[5]) + int'(r[4]) + int'(r[3]);
    return {r[6:0], 1'(ones % 2)};
  endfunction

  // Row seen by the player: wall everywhere except the 128 pixels starting at 2*r
  function automatic logic [W-1:0] exp_line(input logic [7:0] r, input bit en);
    logic [W-1:0] l;
    int start;
    start = 2 * int'(r);
    for (int x = 0; x < int'(W); x++)
      l[x] = en && !(x >= start && x < start + int'(GAP));
    return l;
  endfunction

  // Pulse clk_lfsr for h cycles high, l cycles low, updating the model if enabled
  task automatic strobe(input int h, input int l);
    clk_lfsr = 1'b1;
    repeat (h) @(negedge clk_i);
    clk_lfsr = 1'b0;
    repeat (l) @(negedge clk_i);
    if (en_i) model = model_step(model);
  endtask

  initial begin
    bit   seen [256];
    int   n_seen;
    int   lat;
    logic [7:0] old;

    rst_i = 1'b1; en_i = 1'b1; clk_lfsr = 1'b0; model = 8'hA5;
    repeat (3) @(negedge clk_i);
    check("reset_rand", W'(rand_num), W'(8'hA5));
    check("reset_line", line_o, '0);

    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("seed_line", line_o, exp_line(8'hA5, 1'b1));
    check("seed_rand", W'(rand_num), W'(model));

    // Single long strobe: latency, value and single advance
    @(negedge clk_i);
    old = rand_num;
    clk_lfsr = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      lat++;
      if (rand_num !== old) break;
    end
    check("latency", W'(lat), W'(LAT));
    check("first_step", W'(rand_num), W'(8'h4A));
    @(posedge clk_i); #1;
    check("first_line", line_o, exp_line(8'h4A, 1'b1));
    repeat (80 - lat - 1) @(negedge clk_i);
    clk_lfsr = 1'b0;
    repeat (5) @(negedge clk_i);
    model = model_step(model);
    check("one_advance", W'(rand_num), W'(model));

    // Full period with random strobe timing
    foreach (seen[i]) seen[i] = 1'b0;
    seen[rand_num] = 1'b1;
    n_seen = 1;
    for (int s = 0; s < 254; s++) begin
      strobe($urandom_range(2, 5), $urandom_range(3, 5));
      check("seq_rand", W'(rand_num), W'(model));
      if (!seen[rand_num] && rand_num != 8'h00) n_seen++;
      seen[rand_num] = 1'b1;
      if (s % 32 == 0) check("seq_line", line_o, exp_line(model, 1'b1));
    end
    check("period_return", W'(rand_num), W'(8'hA5));
    check("distinct_vals", W'(n_seen), W'(255));

    // Enable low: freeze and blank, then restore the same line
    en_i = 1'b0;
    @(negedge clk_i);
    check("blank_line", line_o, '0);
    old = rand_num;
    strobe(4, 4);
    check("frozen_rand", W'(rand_num), W'(old));
    check("frozen_line", line_o, '0);
    en_i = 1'b1;
    @(negedge clk_i);
    check("restore_line", line_o, exp_line(old, 1'b1));

    // Random enable per strobe, enable stable across each strobe
    for (int s = 0; s < 30; s++) begin
      en_i = 1'($urandom_range(0, 1));
      strobe($urandom_range(2, 8), $urandom_range(3, 8));
      check("rnd_rand", W'(rand_num), W'(model));
      check("rnd_line", line_o, exp_line(model, en_i));
    end

    // Asynchronous reset mid-cycle
    en_i = 1'b1;
    strobe(3, 3);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    check("async_rand", W'(rand_num), W'(8'hA5));
    check("async_line", line_o, '0);
    clk_lfsr = 1'b1;
    repeat (4) @(negedge clk_i);
    clk_lfsr = 1'b0;
    repeat (3) @(negedge clk_i);
    check("held_rand", W'(rand_num), W'(8'hA5));
    rst_i = 1'b0;
    model = 8'hA5;
    repeat (2) @(negedge clk_i);
    check("post_rst_rand", W'(rand_num), W'(model));
    check("post_rst_line", line_o, exp_line(model, 1'b1));
    strobe(3, 4);
    check("post_rst_step", W'(rand_num), W'(model));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
